alu_cmd_unit: RTL and testbench
===============================

# alu_cmd_unit

Command-side controller for the shared `alu` datapath: accepts ALU operations over a valid/ready command interface, buffers them in a small FIFO, issues one per cycle to an internal `alu` instance, and returns the registered result and flags over a valid/ready response interface. It sits between the instruction/control logic and the combinational `alu`. It is the sequential driver for that datapath, with optional carry chaining for multi-word arithmetic.

## Interface
- `WIDTH`, 4, operand/result width passed to the `alu` instance
- `DEPTH`, 4, command FIFO entries; power of two, ≥ 2
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `cmd_valid` in 1 — command present
- `cmd_ready` out 1 — FIFO can accept; equals not-full
- `cmd_opcode` in 4 — operation, encoded per `ops` package
- `cmd_a`, `cmd_b` in WIDTH — operands
- `cmd_cin` in 1 — explicit carry-in
- `cmd_chain` in 1 — use stored carry instead of `cmd_cin` (see Configuration)
- `rsp_valid` out 1 — result register holds a result
- `rsp_ready` in 1 — consumer accepts result
- `rsp_y` out WIDTH — result
- `rsp_cout`, `rsp_overflow`, `rsp_negative`, `rsp_zero` out 1 each — ALU flags for `rsp_y`
- `busy` out 1 — FIFO non-empty or `rsp_valid`
- `count` out $clog2(DEPTH+1) — FIFO occupancy

## Operation
- Push: `cmd_valid && cmd_ready` writes {opcode, a, b, cin, chain} at the write pointer. `cmd_ready` depends only on full, never on a same-cycle pop.
- Issue: the FIFO head drives the `alu` inputs combinationally.
- Capture: `capture = !empty && (!rsp_valid || rsp_ready)`.
  - On capture, `y` and the four flags load into the result register, the head pops, and `rsp_valid` sets.
- Response:
  - `rsp_valid && rsp_ready` without capture clears `rsp_valid`.
  - With capture, `rsp_valid` stays 1 and the new result replaces the old.
- While `rsp_valid && !rsp_ready`, all `rsp_*` outputs are held stable.
- Pointers wrap modulo DEPTH.
- Count:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- FSM (state register, drives `busy`):
  - IDLE: empty and !rsp_valid.
  - RUN: captures may proceed.
  - STALL: rsp_valid, !rsp_ready, !empty.
  - Transitions:
    - IDLE→RUN on push.
    - RUN→STALL when the result is not taken and the FIFO is non-empty.
    - STALL→RUN on `rsp_ready`.
    - RUN→IDLE when the FIFO drains and the result is taken.
- Arithmetic and flag semantics are exactly those of `alu`. This block never alters `y` or the flags.
- Full FIFO: push is ignored and `cmd_ready` is 0. Empty FIFO: there is no bypass.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_y`=0, all flags 0, `busy`=0, `count`=0, FSM=IDLE, carry register=0.
- Reset mid-operation flushes the FIFO and drops the pending result. There is no response for flushed commands.
- Latency: a command accepted at edge N appears at the head at N+1. It is captured at edge N+1 if the result path is free, so `rsp_valid` is high in cycle N+2.
- Throughput is one result per cycle when `rsp_ready` is held high.
- Commands complete strictly in order.

## Configuration
- `ALU_CMD_CHAIN_EN` defined:
  - A 1-bit carry register loads `cout` on every capture.
  - A command with `cmd_chain`=1 issues with `cin` = carry register; otherwise it uses `cmd_cin`.
  - Reset and flush clear the carry register.
- Not defined:
  - No carry register exists.
  - `cmd_chain` is ignored and not stored in the FIFO.
  - `cin` always equals `cmd_cin`.

## Structure
- `ops` package: opcode constants (existing) plus the `alu_cmd_t` struct typedef {opcode, a, b, cin, chain} and FSM state enum.
- Sub-module `alu_cmd_fifo`: parameterized synchronous FIFO of `alu_cmd_t`, exposing full, empty and count.
- Top instantiates `alu_cmd_fifo` and the existing `alu #(WIDTH)`, and owns the result register, FSM and carry logic.

## Test plan
- Reset, then LL_SHIFT_OP a=0001 b=0001 with `rsp_ready`=1 → `rsp_valid` in cycle N+2, `rsp_y`=0010, `rsp_zero`=0.
- Four back-to-back commands (AND 1111&0111, OR 1010|0101, XOR 1100^1010, NOT 1000) with `rsp_ready`=1 → `rsp_y` = 0111, 1111, 0110, 0111 on consecutive cycles.
- `rsp_ready`=0 while pushing DEPTH+1 commands:
  - one command is captured; `count` reaches DEPTH and `cmd_ready`=0.
  - `rsp_y` is held; FSM=STALL.
  - Then release → all results arrive in order.
- With `ALU_CMD_CHAIN_EN`: ADD_OP 1111+0001 cin=0 → `rsp_y`=0000, `rsp_cout`=1. Then ADD_OP 0000+0000 chain=1 → `rsp_y`=0001.
- Assert `rst` with 3 queued commands and `rsp_valid`=1 → next cycle `count`=0, `rsp_valid`=0, `busy`=0, and no stale responses follow.

Source files
------------

// File: rtl/alu_cmd_unit_pkg.sv
// Shared ALU opcode set, queued-command record and controller state encoding.
// The chain field exists only when ALU_CMD_CHAIN_EN is defined.
package alu_cmd_unit_pkg;

    // Operand width of a stored command; the top's WIDTH must match it.
    localparam int CMD_WIDTH = 4;

    localparam logic [3:0] ADD_OP      = 4'h0;
    localparam logic [3:0] SUB_OP      = 4'h1;
    localparam logic [3:0] AND_OP      = 4'h2;
    localparam logic [3:0] OR_OP       = 4'h3;
    localparam logic [3:0] XOR_OP      = 4'h4;
    localparam logic [3:0] NOT_OP      = 4'h5;
    localparam logic [3:0] LL_SHIFT_OP = 4'h6;
    localparam logic [3:0] LR_SHIFT_OP = 4'h7;
    localparam logic [3:0] PASS_B_OP   = 4'h8;

    typedef struct packed {
        logic [3:0]           opcode;
        logic [CMD_WIDTH-1:0] a;
        logic [CMD_WIDTH-1:0] b;
        logic                 cin;
`ifdef ALU_CMD_CHAIN_EN
        logic                 chain;
`endif
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } alu_cmd_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath: arithmetic, logic and shift ops with
// carry, signed-overflow, negative and zero flags.
module alu
    import alu_cmd_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = '0;
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (opcode)
            ADD_OP: begin
                sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                y        = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            // Subtract is a + ~b + cin, so cin=1 gives a plain a-b.
            SUB_OP: begin
                sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                y        = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            AND_OP:      y = a & b;
            OR_OP:       y = a | b;
            XOR_OP:      y = a ^ b;
            NOT_OP:      y = ~a;
            LL_SHIFT_OP: y = a << b[SW-1:0];
            LR_SHIFT_OP: y = a >> b[SW-1:0];
            PASS_B_OP:   y = b;
            default:     y = '0;
        endcase
    end

    assign negative = y[WIDTH-1];
    assign zero     = (y == '0);

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module alu_cmd_fifo
    import alu_cmd_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  alu_cmd_t                   wr_data,
    input  logic                       pop,
    output alu_cmd_t                   rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    alu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_unit.sv
// Queues ALU commands, issues the FIFO head to the alu and registers its
// result for a valid/ready consumer. ALU_CMD_CHAIN_EN enables carry chaining.
module alu_cmd_unit
    import alu_cmd_unit_pkg::*;
#(
    parameter int WIDTH = CMD_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_opcode,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic                       cmd_cin,
    input  logic                       cmd_chain,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_y,
    output logic                       rsp_cout,
    output logic                       rsp_overflow,
    output logic                       rsp_negative,
    output logic                       rsp_zero,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    alu_cmd_t         wr_cmd, head_cmd;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push, capture, empty_nxt, alu_cin;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout, alu_ovf, alu_neg, alu_zero;

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    alu_cmd_state_e   state_q, state_d;

    assign push      = cmd_valid && !fifo_full;
    assign cmd_ready = !fifo_full;
    assign capture   = !fifo_empty && (!rsp_valid_q || rsp_ready);
    assign empty_nxt = !push && ((fifo_count == '0) || ((fifo_count == CW'(1)) && capture));

    always_comb begin
        wr_cmd        = '0;
        wr_cmd.opcode = cmd_opcode;
        wr_cmd.a      = cmd_a;
        wr_cmd.b      = cmd_b;
        wr_cmd.cin    = cmd_cin;
`ifdef ALU_CMD_CHAIN_EN
        wr_cmd.chain  = cmd_chain;
`endif
    end

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (capture),
        .rd_data (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef ALU_CMD_CHAIN_EN
    logic carry_q, carry_d;

    // Carry follows the most recently captured result, i.e. the previous command in order.
    assign carry_d = capture ? alu_cout : carry_q;
    assign alu_cin = head_cmd.chain ? carry_q : head_cmd.cin;

    always_ff @(posedge clk) begin
        if (rst) carry_q <= 1'b0;
        else     carry_q <= carry_d;
    end
`else
    logic unused_chain;

    assign unused_chain = cmd_chain;
    assign alu_cin      = head_cmd.cin;
`endif

    alu #(.WIDTH(WIDTH)) u_alu (
        .opcode   (head_cmd.opcode),
        .a        (head_cmd.a),
        .b        (head_cmd.b),
        .cin      (alu_cin),
        .y        (alu_y),
        .cout     (alu_cout),
        .overflow (alu_ovf),
        .negative (alu_neg),
        .zero     (alu_zero)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_y_d     = alu_y;
            rsp_flags_d = {alu_cout, alu_ovf, alu_neg, alu_zero};
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Transitions look at next-cycle FIFO/result occupancy so IDLE always means nothing pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (push) state_d = ST_RUN;
            ST_RUN: begin
                if (empty_nxt && !rsp_valid_d)
                    state_d = ST_IDLE;
                else if (rsp_valid_q && !rsp_ready && !fifo_empty)
                    state_d = ST_STALL;
            end
            ST_STALL: if (rsp_ready) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_cout     = rsp_flags_q[3];
    assign rsp_overflow = rsp_flags_q[2];
    assign rsp_negative = rsp_flags_q[1];
    assign rsp_zero     = rsp_flags_q[0];
    assign busy         = (state_q != ST_IDLE);
    assign count        = fifo_count;

endmodule

// File: tb/tb_alu_cmd_unit.sv
// Directed scoreboard bench for alu_cmd_unit: latency, throughput, stall/full,
// carry chaining (when ALU_CMD_CHAIN_EN is defined) and mid-operation reset.
module tb_alu_cmd_unit;
    import alu_cmd_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_cin, cmd_chain;
    logic [3:0] cmd_opcode, cmd_a, cmd_b;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_y;
    logic       rsp_cout, rsp_overflow, rsp_negative, rsp_zero, busy;
    logic [2:0] count;

    typedef struct packed {
        logic [3:0] y;
        logic       cout;
        logic       ovf;
        logic       neg;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
`ifdef ALU_CMD_CHAIN_EN
    logic model_carry = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_cmd_unit #(.WIDTH(4), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_cin      (cmd_cin),
        .cmd_chain    (cmd_chain),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .rsp_negative (rsp_negative),
        .rsp_zero     (rsp_zero),
        .busy         (busy),
        .count        (count)
    );

    function automatic exp_t aluModel(input logic [3:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic cin);
        exp_t       r;
        logic [4:0] s;
        r = '0;
        s = '0;
        case (op)
            ADD_OP: begin
                s      = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                r.y    = s[3:0];
                r.cout = s[4];
                r.ovf  = (a[3] == b[3]) && (r.y[3] != a[3]);
            end
            SUB_OP: begin
                s      = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
                r.y    = s[3:0];
                r.cout = s[4];
                r.ovf  = (a[3] != b[3]) && (r.y[3] != a[3]);
            end
            AND_OP:      r.y = a & b;
            OR_OP:       r.y = a | b;
            XOR_OP:      r.y = a ^ b;
            NOT_OP:      r.y = ~a;
            LL_SHIFT_OP: r.y = a << b[1:0];
            LR_SHIFT_OP: r.y = a >> b[1:0];
            PASS_B_OP:   r.y = b;
            default:     r.y = 4'h0;
        endcase
        r.neg  = r.y[3];
        r.zero = (r.y == 4'h0);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input logic cin, input logic chain);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_cin    = cin;
        cmd_chain  = chain;
    endtask

    task automatic idleCmd();
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
    endtask

    // Accepted commands enter the scoreboard; handshaken responses leave it.
    task automatic tick();
        exp_t e;
        exp_t got;
        logic cin_eff;
        @(negedge clk);
        if (cmd_valid && cmd_ready && !rst) begin
            cin_eff = cmd_cin;
`ifdef ALU_CMD_CHAIN_EN
            if (cmd_chain) cin_eff = model_carry;
`endif
            e = aluModel(cmd_opcode, cmd_a, cmd_b, cin_eff);
`ifdef ALU_CMD_CHAIN_EN
            model_carry = e.cout;
`endif
            sb.push_back(e);
        end
        if (rsp_valid && rsp_ready) begin
            got = {rsp_y, rsp_cout, rsp_overflow, rsp_negative, rsp_zero};
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_valid), 0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_rsp", 32'(got), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxCycles);
        for (int i = 0; i < maxCycles && sb.size() != 0; i++) tick();
        checkOutput("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        rst        = 1'b1;
        rsp_ready  = 1'b1;
        cmd_opcode = 4'h0;
        cmd_a      = 4'h0;
        cmd_b      = 4'h0;
        cmd_cin    = 1'b0;
        idleCmd();
        tick();
        tick();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_y", 32'(rsp_y), 0);
        checkOutput("rst_flags", 32'({rsp_cout, rsp_overflow, rsp_negative, rsp_zero}), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;

        $display("[TB] latency");
        applyStimulus(LL_SHIFT_OP, 4'b0001, 4'b0001, 1'b0, 1'b0);
        tick();
        idleCmd();
        checkOutput("lat_n1_valid", 32'(rsp_valid), 0);
        checkOutput("lat_n1_count", 32'(count), 1);
        checkOutput("lat_n1_busy", 32'(busy), 1);
        tick();
        checkOutput("lat_n2_valid", 32'(rsp_valid), 1);
        checkOutput("lat_n2_y", 32'(rsp_y), 32'(4'b0010));
        checkOutput("lat_n2_zero", 32'(rsp_zero), 0);
        tick();
        checkOutput("lat_done_valid", 32'(rsp_valid), 0);
        checkOutput("lat_done_busy", 32'(busy), 0);

        $display("[TB] back-to-back");
        applyStimulus(AND_OP, 4'b1111, 4'b0111, 1'b0, 1'b0);
        tick();
        applyStimulus(OR_OP, 4'b1010, 4'b0101, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_and", 32'({rsp_valid, rsp_y}), 32'({1'b1, 4'b0111}));
        applyStimulus(XOR_OP, 4'b1100, 4'b1010, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_or", 32'({rsp_valid, rsp_y}), 32'({1'b1, 4'b1111}));
        applyStimulus(NOT_OP, 4'b1000, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_xor", 32'({rsp_valid, rsp_y}), 32'({1'b1, 4'b0110}));
        idleCmd();
        tick();
        checkOutput("b2b_not", 32'({rsp_valid, rsp_y}), 32'({1'b1, 4'b0111}));
        drain(20);

        $display("[TB] stall and full");
        rsp_ready = 1'b0;
        applyStimulus(ADD_OP, 4'b0011, 4'b0100, 1'b0, 1'b0);
        tick();
        applyStimulus(SUB_OP, 4'b0101, 4'b0011, 1'b1, 1'b0);
        tick();
        applyStimulus(ADD_OP, 4'b0111, 4'b0001, 1'b0, 1'b0);
        tick();
        applyStimulus(SUB_OP, 4'b0000, 4'b0001, 1'b1, 1'b0);
        tick();
        applyStimulus(LR_SHIFT_OP, 4'b1000, 4'b0010, 1'b0, 1'b0);
        tick();
        checkOutput("full_count", 32'(count), 4);
        checkOutput("full_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("stall_y_held", 32'({rsp_valid, rsp_y}), 32'({1'b1, 4'b0111}));
        checkOutput("stall_state", 32'(dut.state_q), 32'(ST_STALL));
        applyStimulus(PASS_B_OP, 4'b0000, 4'b1010, 1'b0, 1'b0);
        tick();
        checkOutput("full_push_ignored", 32'(count), 4);
        checkOutput("stall_y_held2", 32'(rsp_y), 32'(4'b0111));
        idleCmd();
        rsp_ready = 1'b1;
        drain(40);
        checkOutput("stall_end_busy", 32'(busy), 0);
        checkOutput("stall_end_state", 32'(dut.state_q), 32'(ST_IDLE));

        $display("[TB] carry chain");
        applyStimulus(ADD_OP, 4'b1111, 4'b0001, 1'b0, 1'b0);
        tick();
        applyStimulus(ADD_OP, 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        idleCmd();
        checkOutput("chain_first", 32'({rsp_y, rsp_cout}), 32'({4'b0000, 1'b1}));
        tick();
`ifdef ALU_CMD_CHAIN_EN
        checkOutput("chain_second", 32'(rsp_y), 32'(4'b0001));
`else
        checkOutput("chain_second", 32'(rsp_y), 32'(4'b0000));
`endif
        drain(20);

        $display("[TB] mid-operation reset");
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(PASS_B_OP, 4'b0000, 4'(i), 1'b0, 1'b0);
            tick();
        end
        idleCmd();
        checkOutput("pre_rst_count", 32'(count), 3);
        checkOutput("pre_rst_valid", 32'(rsp_valid), 1);
        rst = 1'b1;
        sb.delete();
`ifdef ALU_CMD_CHAIN_EN
        model_carry = 1'b0;
`endif
        tick();
        checkOutput("flush_count", 32'(count), 0);
        checkOutput("flush_valid", 32'(rsp_valid), 0);
        checkOutput("flush_busy", 32'(busy), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("no_stale", 32'(rsp_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
